// File: rtl/id_ex_skid_if.sv
// Valid/ready bus carrying one ID/EX instruction.
// The producer uses the master modport and the consumer uses the slave modport.
interface id_ex_skid_if #(
    parameter int DATA_W = 32,
    parameter int NDATA  = 4,
    parameter int CTRL_W = 11,
    parameter int META_W = 16
);
    logic                      valid;
    logic                      ready;
    logic [NDATA*DATA_W-1:0]   data;
    logic [CTRL_W-1:0]         ctrl;
    logic [META_W-1:0]         meta;

    modport master (output valid, data, ctrl, meta, input  ready);
    modport slave  (input  valid, data, ctrl, meta, output ready);
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with a 2-entry skid buffer, a flush-to-bubble path,
// and saturating stall/flush counters.
module id_ex_skid_stage #(
    parameter int DATA_W = 32,
    parameter int NDATA  = 4,
    parameter int CTRL_W = 11,
    parameter int META_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_skid_if.slave        in_if,
    id_ex_skid_if.master       out_if,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    localparam int DW    = NDATA * DATA_W;
    localparam int PAY_W = DW + CTRL_W + META_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay_reg, out_pay_next;
    logic [PAY_W-1:0] skid_pay_reg, skid_pay_next;
    logic             out_valid_reg, out_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic             in_fire;
    logic             out_fire;

    assign in_pay   = {in_if.data, in_if.ctrl, in_if.meta};
    assign in_fire  = in_if.valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_if.ready;

    always_comb begin
        out_pay_next    = out_pay_reg;
        skid_pay_next   = skid_pay_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so only the drain of the skid can happen
            if (out_fire) begin
                out_pay_next    = skid_pay_reg;
                skid_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_reg || out_fire) begin
                out_pay_next   = in_pay;
                out_valid_next = 1'b1;
            end else begin
                skid_pay_next   = in_pay;
                skid_valid_next = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_next = 1'b0;
        end
        // Registered so out_ready never reaches in_ready combinationally
        in_ready_next = ~skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pay_reg    <= '0;
            skid_pay_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            out_pay_reg    <= out_pay_next;
            skid_pay_reg   <= skid_pay_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_if.ready  = in_ready_reg;
    assign out_if.valid = out_valid_reg;
    assign out_if.data  = out_pay_reg[PAY_W-1 -: DW];
    assign out_if.ctrl  = out_valid_reg ? out_pay_reg[META_W +: CTRL_W] : '0;
    assign out_if.meta  = out_pay_reg[META_W-1:0];

    // Counter 0 tracks stalls, counter 1 tracks flushes that squash live entries
    logic [1:0] cnt_hit;
    assign cnt_hit = {flush & (out_valid_reg | skid_valid_reg),
                      out_valid_reg & ~out_if.ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_hit[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt = g_cnt[1].cnt_reg;
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: the stage is modelled as a 2-deep FIFO
// (in_ready = fewer than two held, out_valid = at least one held), cleared by flush.
module tb_id_ex_skid_stage;
    localparam int DATA_W = 32;
    localparam int NDATA  = 4;
    localparam int CTRL_W = 11;
    localparam int META_W = 16;
    localparam int CNT_W  = 4;
    localparam int DW     = NDATA * DATA_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DW-1:0]     d;
        logic [CTRL_W-1:0] c;
        logic [META_W-1:0] m;
    } ent_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    id_ex_skid_if #(.DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .META_W(META_W)) in_if ();
    id_ex_skid_if #(.DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .META_W(META_W)) out_if ();

    id_ex_skid_stage #(
        .DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .META_W(META_W), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (in_if),
        .out_if   (out_if),
        .flush    (flush),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_out   = 0;
    int   occ_pre = 0;
    int   stall_m = 0;
    int   flush_m = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] w);
        ent_t e;
        e.d = {NDATA{w}};
        e.c = w[CTRL_W-1:0];
        e.m = w[META_W-1:0];
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.d = {$urandom, $urandom, $urandom, $urandom};
        e.c = CTRL_W'($urandom);
        e.m = META_W'($urandom);
        return e;
    endfunction

    // Monitor: compares DUT against the model state, then advances the counters
    // and pops the head when the model says a consume happens this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            occ_pre = exp_q.size();
            chk("out_valid", DW'(out_if.valid), DW'(occ_pre > 0));
            chk("in_ready",  DW'(in_if.ready),  DW'(occ_pre < 2));
            chk("stall_cnt", DW'(stall_cnt),    DW'(stall_m));
            chk("flush_cnt", DW'(flush_cnt),    DW'(flush_m));
            if (occ_pre == 0) chk("bubble_ctrl", DW'(out_if.ctrl), '0);
            if (occ_pre > 0 && !out_if.ready && stall_m < CMAX) stall_m++;
            if (flush && occ_pre > 0 && flush_m < CMAX) flush_m++;
            if (occ_pre > 0 && out_if.ready) begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_if.data, mon_e.d);
                chk("out_ctrl", DW'(out_if.ctrl), DW'(mon_e.c));
                chk("out_meta", DW'(out_if.meta), DW'(mon_e.m));
                n_out++;
                $display("OUT %0d data=%h ctrl=%h meta=%h", n_out, out_if.data, out_if.ctrl, out_if.meta);
            end
        end
    end

    // Drive one cycle; acceptance is decided from the model occupancy before the edge.
    task automatic cycle(input logic v, input ent_t e, input logic ordy, input logic fl);
        in_if.valid  = v;
        in_if.data   = e.d;
        in_if.ctrl   = e.c;
        in_if.meta   = e.m;
        out_if.ready = ordy;
        flush        = fl;
        @(negedge clk);
        #1;
        if (fl) exp_q.delete();
        else if (v && occ_pre < 2) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.ctrl   = '0;
        in_if.meta   = '0;
        out_if.ready = 1'b0;
        flush        = 1'b0;
        exp_q.delete();
        stall_m = 0;
        flush_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    ent_t z, a, b, c, x;

    initial begin
        z = mk(32'h0);
        a = mk(32'hA);
        b = mk(32'hB);
        c = mk(32'hC);
        rst_n = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_valid", DW'(out_if.valid), '0);
        chk("rst_in_ready",  DW'(in_if.ready),  DW'(1));
        chk("rst_out_data",  out_if.data,       '0);
        chk("rst_out_ctrl",  DW'(out_if.ctrl),  '0);
        chk("rst_out_meta",  DW'(out_if.meta),  '0);
        chk("rst_stall",     DW'(stall_cnt),    '0);
        chk("rst_flush",     DW'(flush_cnt),    '0);

        // Streaming
        cycle(1'b1, mk(32'h11), 1'b1, 1'b0);
        cycle(1'b1, mk(32'h22), 1'b1, 1'b0);
        cycle(1'b1, mk(32'h33), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, z, 1'b1, 1'b0);
        chk("stream_stall", DW'(stall_cnt), '0);

        // Back-pressure: A in output, B in skid, C refused until drained
        do_reset();
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        chk("bp_in_ready", DW'(in_if.ready), '0);
        repeat (3) cycle(1'b1, c, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, c, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, z, 1'b1, 1'b0);
        chk("bp_stall", DW'(stall_cnt), DW'(4));

        // Flush with a full skid and a new instruction present
        do_reset();
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        cycle(1'b1, c, 1'b0, 1'b1);
        chk("fl_out_valid", DW'(out_if.valid), '0);
        chk("fl_out_ctrl",  DW'(out_if.ctrl),  '0);
        chk("fl_in_ready",  DW'(in_if.ready),  DW'(1));
        chk("fl_cnt",       DW'(flush_cnt),    DW'(1));
        repeat (3) cycle(1'b0, z, 1'b1, 1'b0);

        // Bubble masking keeps the stale payload but zeroes control
        do_reset();
        x   = mk(32'h5555);
        x.c = 11'h7FF;
        cycle(1'b1, x, 1'b1, 1'b0);
        cycle(1'b0, z, 1'b1, 1'b0);
        chk("bub_valid", DW'(out_if.valid), '0);
        chk("bub_ctrl",  DW'(out_if.ctrl),  '0);
        chk("bub_data",  out_if.data,       x.d);

        // Stall counter saturation
        do_reset();
        cycle(1'b1, a, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, z, 1'b0, 1'b0);
        chk("sat_stall", DW'(stall_cnt), DW'(CMAX));
        cycle(1'b0, z, 1'b0, 1'b0);
        chk("sat_hold", DW'(stall_cnt), DW'(CMAX));
        repeat (2) cycle(1'b0, z, 1'b1, 1'b0);

        // Asynchronous reset between edges with both entries full
        do_reset();
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("ar_out_valid", DW'(out_if.valid), '0);
        chk("ar_in_ready",  DW'(in_if.ready),  DW'(1));
        chk("ar_out_ctrl",  DW'(out_if.ctrl),  '0);
        chk("ar_out_data",  out_if.data,       '0);
        chk("ar_stall",     DW'(stall_cnt),    '0);
        chk("ar_flush",     DW'(flush_cnt),    '0);
        exp_q.delete();
        stall_m     = 0;
        flush_m     = 0;
        in_if.valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, z, 1'b1, 1'b0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 4) != 0, rnd_ent(), ($urandom % 3) != 0, ($urandom % 20) == 0);
        end
        repeat (4) cycle(1'b0, z, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
